// File: rtl/sar_result_avg_fifo.sv
// SAR result averager with show-ahead result FIFO.
// Edge-detects the end-of-conversion strobe, sums 1/2/4/8 conversions, and
// pushes the truncated average into a DEPTH-entry FIFO with a sticky overflow flag.
module sar_result_avg_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [1:0]                 osr,
    input  logic [9:0]                 sar,
    input  logic                       eoc,
    output logic [9:0]                 dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    input  logic                       clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshake: an entry leaves the FIFO on any rising clk edge where
    // dout_valid and dout_ready are both high; dout is the head while valid.

    logic             r_eoc_d;
    logic [12:0]      r_acc;
    logic [2:0]       r_cnt;
    logic [1:0]       r_osr_l;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic [9:0]       r_mem [DEPTH];

    logic             w_capture;
    logic [1:0]       w_osr_eff;
    logic [12:0]      w_sum;
    logic [3:0]       w_len;
    logic             w_last;
    logic [9:0]       w_result;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_push_ok;
    logic             w_drop;

    assign w_capture  = en & eoc & ~r_eoc_d;
    assign dout_valid = (r_count != '0);
    assign w_pop      = dout_valid & dout_ready;
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_push     = w_capture & w_last;
    assign w_push_ok  = w_push & (~w_full | w_pop);
    assign w_drop     = w_push & w_full & ~w_pop;
    assign dout       = dout_valid ? r_mem[r_rd_ptr] : 10'd0;
    assign fifo_count = r_count;
    assign overflow   = r_ovf;

    // Window arithmetic: the osr in force is the live input at window start.
    always_comb begin
        w_osr_eff = r_osr_l;
        if (r_cnt == 3'd0) begin
            w_osr_eff = osr;
        end
        w_sum    = r_acc + {3'b000, sar};
        w_len    = 4'd1 << w_osr_eff;
        w_last   = (({1'b0, r_cnt} + 4'd1) == w_len);
        w_result = w_sum[9:0];
        case (w_osr_eff)
            2'd0:    w_result = w_sum[9:0];
            2'd1:    w_result = w_sum[10:1];
            2'd2:    w_result = w_sum[11:2];
            default: w_result = w_sum[12:3];
        endcase
    end

    // Accumulator, sample counter and eoc edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eoc_d <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_osr_l <= '0;
        end else if (!en) begin
            r_eoc_d <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_eoc_d <= eoc;
            if (w_capture) begin
                if (r_cnt == 3'd0) begin
                    r_osr_l <= osr;
                end
                if (w_last) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 3'd1;
                end
            end
        end
    end

    // FIFO pointers and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow; a drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    // Storage array; contents are only observable through valid entries.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_result;
        end
    end
endmodule

// File: tb/tb_sar_result_avg_fifo.sv
// Bench for sar_result_avg_fifo: directed scenarios plus random traffic,
// every cycle compared with a window/queue reference model.
module tb_sar_result_avg_fifo;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] osr;
    logic [9:0] sar;
    logic       eoc;
    logic [9:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       clr_ovf;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [9:0] exp_q[$];
    int         m_sum;
    int         m_n;
    int         m_len;
    bit         m_eoc_d;
    bit         m_ovf;

    sar_result_avg_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .osr        (osr),
        .sar        (sar),
        .eoc        (eoc),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    // clock: 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_sum   = 0;
        m_n     = 0;
        m_len   = 1;
        m_eoc_d = 0;
        m_ovf   = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_valid"}, {31'd0, dout_valid}, {31'd0, exp_q.size() != 0});
        chk({tag, "_count"}, {29'd0, fifo_count}, exp_q.size());
        chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, m_ovf});
        if (exp_q.size() != 0) chk({tag, "_dout"}, {22'd0, dout}, {22'd0, exp_q[0]});
    endtask

    // one clock: predict from the inputs held this cycle, then advance and compare
    task automatic tick();
        bit         cap, pop, push, drop;
        logic [9:0] res;
        push = 0;
        res  = '0;
        if (!rst_n) begin
            model_reset();
        end else begin
            cap = en && eoc && !m_eoc_d;
            pop = (exp_q.size() != 0) && dout_ready;
            if (!en) begin
                m_sum = 0;
                m_n   = 0;
            end else if (cap) begin
                if (m_n == 0) m_len = 1 << osr;
                m_sum += sar;
                m_n++;
                if (m_n == m_len) begin
                    push  = 1;
                    res   = 10'(m_sum / m_len);
                    m_sum = 0;
                    m_n   = 0;
                end
            end
            m_eoc_d = en ? eoc : 1'b0;
            drop = push && (exp_q.size() == DEPTH) && !pop;
            if (pop) void'(exp_q.pop_front());
            if (push && !drop) exp_q.push_back(res);
            if (drop) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
        end
        @(posedge clk);
        #1;
        check_state("cyc");
    endtask

    task automatic pulse(input logic [9:0] v, input logic rdy);
        eoc = 1'b1;
        sar = v;
        dout_ready = rdy;
        tick();
        eoc = 1'b0;
        dout_ready = 1'b0;
        tick();
    endtask

    task automatic drain();
        dout_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();
        dout_ready = 1'b0;
        chk("drain_empty", {29'd0, fifo_count}, 0);
    endtask

    initial begin
        logic [9:0] seq30 [4];
        logic [9:0] seq33 [4];
        seq30 = '{10'd5, 10'd1023, 10'd0, 10'd512};
        seq33 = '{10'd2, 10'd3, 10'd4, 10'd10};
        rst_n = 1'b1; en = 1'b0; osr = 2'd0; sar = '0; eoc = 1'b0;
        dout_ready = 1'b0; clr_ovf = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", {31'd0, dout_valid}, 0);
        chk("rst_count", {29'd0, fifo_count}, 0);
        chk("rst_ovf", {31'd0, overflow}, 0);
        chk("rst_dout", {22'd0, dout}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        en = 1'b1;
        tick();

        // four single-sample windows fill the FIFO in order
        for (int i = 0; i < 4; i++) pulse(seq30[i], 1'b0);
        chk("r30_count", {29'd0, fifo_count}, 4);
        chk("r30_ovf", {31'd0, overflow}, 0);
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("r30_order", {22'd0, dout}, {22'd0, seq30[i]});
            tick();
        end
        dout_ready = 1'b0;

        // four-sample window, truncated average
        osr = 2'd2;
        pulse(10'd10, 1'b0);
        pulse(10'd11, 1'b0);
        pulse(10'd12, 1'b0);
        chk("r31_nopush", {29'd0, fifo_count}, 0);
        pulse(10'd13, 1'b0);
        chk("r31_count", {29'd0, fifo_count}, 1);
        chk("r31_dout", {22'd0, dout}, 11);
        drain();

        // eight full-scale samples, osr change mid-window ignored
        osr = 2'd3;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) osr = 2'd0;
            pulse(10'd1023, 1'b0);
            if (i == 6) chk("r32_open", {29'd0, fifo_count}, 0);
        end
        chk("r32_count", {29'd0, fifo_count}, 1);
        chk("r32_dout", {22'd0, dout}, 1023);
        drain();

        // overflow, push+pop at full, clear
        osr = 2'd0;
        for (int i = 1; i <= 4; i++) pulse(10'(i), 1'b0);
        pulse(10'd9, 1'b0);
        chk("r33_ovf", {31'd0, overflow}, 1);
        chk("r33_count", {29'd0, fifo_count}, 4);
        chk("r33_head", {22'd0, dout}, 1);
        pulse(10'd10, 1'b1);
        chk("r33_fullrw", {29'd0, fifo_count}, 4);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("r33_clr", {31'd0, overflow}, 0);
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("r33_order", {22'd0, dout}, {22'd0, seq33[i]});
            tick();
        end
        dout_ready = 1'b0;

        // held eoc gives one capture
        eoc = 1'b1; sar = 10'd77;
        for (int i = 0; i < 5; i++) tick();
        eoc = 1'b0;
        tick();
        chk("r34_held", {29'd0, fifo_count}, 1);
        drain();

        // en drop discards a partial window
        osr = 2'd1;
        pulse(10'd100, 1'b0);
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        pulse(10'd4, 1'b0);
        pulse(10'd6, 1'b0);
        chk("r34_en_count", {29'd0, fifo_count}, 1);
        chk("r34_en_dout", {22'd0, dout}, 5);
        drain();

        // async reset with stored entries and a half window
        osr = 2'd0;
        for (int i = 0; i < 3; i++) pulse(10'(20 + i), 1'b0);
        osr = 2'd1;
        pulse(10'd50, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("r35_valid", {31'd0, dout_valid}, 0);
        chk("r35_count", {29'd0, fifo_count}, 0);
        chk("r35_dout", {22'd0, dout}, 0);
        chk("r35_ovf", {31'd0, overflow}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        osr = 2'd0;
        tick();
        pulse(10'd7, 1'b0);
        chk("r35_after_dout", {22'd0, dout}, 7);
        chk("r35_after_count", {29'd0, fifo_count}, 1);
        drain();

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            en         = ($urandom_range(0, 15) != 0);
            osr        = 2'($urandom_range(0, 3));
            eoc        = 1'($urandom_range(0, 1));
            sar        = 10'($urandom_range(0, 1023));
            dout_ready = ($urandom_range(0, 3) == 0);
            clr_ovf    = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sar_result_avg_fifo.md
SAR_RESULT_AVG_FIFO -- requirements
Module: sar_result_avg_fifo

Interface
REQ-001 Parameter: DEPTH, 4, number of result FIFO entries; a power of two, at least 2.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: en  input  1  capture enable; low means conversions are ignored and the averaging window is cleared.
REQ-005 Port: osr  input  2  oversampling select; window length is 1, 2, 4 or 8 conversions for osr = 0, 1, 2, 3.
REQ-006 Port: sar  input  10  conversion code from the SAR logic; valid while eoc is high.
REQ-007 Port: eoc  input  1  end-of-conversion strobe from the SAR logic.
REQ-008 Port: dout  output  10  averaged result at the FIFO head.
REQ-009 Port: dout_valid  output  1  high while the FIFO holds at least one entry.
REQ-010 Port: dout_ready  input  1  consumer accepts the head entry.
REQ-011 Port: fifo_count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-012 Port: overflow  output  1  sticky flag; set when a result is dropped.
REQ-013 Port: clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-014 The block SHALL register eoc into eoc_d and define capture = en & eoc & ~eoc_d.
  - An eoc held high for several cycles yields exactly one capture.
REQ-015 On capture, the block SHALL form sum = acc + sar.
  - acc is 13 bits wide and zero-extends sar.
  - The sample counter cnt (3 bits) increments by 1.
REQ-016 When cnt == 0 at capture, the block SHALL latch osr into osr_l.
  - A change on osr inside an open window takes effect only at the next window start.
REQ-017 When cnt + 1 == 2^osr_l at capture, the block SHALL push sum >> osr_l into the FIFO.
  - The result is truncated, not rounded.
  - acc and cnt clear to 0 on the same edge.
  - Otherwise acc <= sum.
REQ-018 Push latency: the pushed entry SHALL be visible on dout/dout_valid immediately after the capture edge when the FIFO was empty (1 clk from eoc rise).
REQ-019 When en = 0, the block SHALL clear acc, cnt and eoc_d every cycle.
  - FIFO contents, the pointers and overflow are kept, and reads continue.
REQ-020 dout SHALL show the head entry without needing a read (show-ahead); it is don't-care when dout_valid = 0.
REQ-021 Pop = dout_valid & dout_ready; on pop the read pointer SHALL advance, with wrap-around modulo DEPTH.
REQ-022 A push when fifo_count == DEPTH with no pop in the same cycle SHALL drop the result and set overflow.
  - The FIFO, pointers and count stay unchanged.
REQ-023 A push and a pop in the same cycle SHALL both succeed at any fill level, including full; fifo_count is unchanged.
REQ-024 When dout_ready is high with an empty FIFO, the block SHALL do nothing.
  - A push into an empty FIFO is never popped in the same cycle.
REQ-025 clr_ovf SHALL clear overflow on the next edge; a drop in the same cycle takes priority and overflow stays 1.
REQ-026 fifo_count SHALL be a registered up/down counter in the range 0..DEPTH.

Reset
REQ-027 Assertion of rst_n = 0 SHALL immediately clear the following:
  - acc, cnt, eoc_d, osr_l, both pointers, fifo_count, dout_valid and overflow all go to 0.
  - dout goes to 10'd0.
REQ-028 Reset mid-window or mid-read SHALL discard partial sums and all stored entries.
  - The first capture after release starts a fresh window.
REQ-029 The block SHALL apply no capture on the first edge after release unless eoc rises after eoc_d has been sampled as 0.

Verification
REQ-030 osr=0, en=1, dout_ready=0, four eoc pulses with sar = 10'd5, 10'd1023, 10'd0, 10'd512:
  - FIFO holds 5, 1023, 0, 512 in order; fifo_count = 4; overflow = 0.
REQ-031 osr=2, pulses sar = 10, 11, 12, 13:
  - Exactly one push, dout = 11 (46>>2).
  - No push after the first three pulses.
REQ-032 osr=3, eight pulses with sar = 1023:
  - dout = 1023, with no overflow of the 13-bit acc.
  - osr switched to 0 after the 3rd pulse does not shorten the window.
REQ-033 FIFO full (count 4), pulse without pop:
  - overflow = 1, count 4, head unchanged.
  - A later pulse with dout_ready = 1 in the same cycle gives count 4 and a new tail entry.
  - clr_ovf then gives overflow = 0.
REQ-034 eoc held high 5 cycles with osr=0: exactly one entry.
  - en dropped after 1 of 2 samples (osr=1), then re-raised, then 2 pulses 4 and 6: one entry = 5.
REQ-035 rst_n pulled low asynchronously with 3 entries and a half window pending:
  - Outputs are 0 before the next clk edge.
  - After release, a single osr=0 pulse with sar=7 yields dout=7, count=1.
